// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with registered status flags, sticky overflow/underflow
// errors and a selectable registered-read or first-word-fall-through output.
module sync_fifo_flagged #(
  parameter int DATA_SIZE  = 8,
  parameter int ADDR_SIZE  = 4,
  parameter int AFULL_LVL  = (2**ADDR_SIZE) - 2,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 wr_inc,
  input  logic                 rd_inc,
  input  logic                 clr_err,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 wr_full,
  output logic                 rd_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   wr_count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 2**ADDR_SIZE;

  typedef logic [ADDR_SIZE:0] cnt_t;

  localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
  localparam cnt_t AFULL_C  = cnt_t'(AFULL_LVL);
  localparam cnt_t AEMPTY_C = cnt_t'(AEMPTY_LVL);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  cnt_t                 wr_ptr_q, wr_ptr_d;
  cnt_t                 rd_ptr_q, rd_ptr_d;
  cnt_t                 count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 afull_q, afull_d;
  logic                 aempty_q, aempty_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 wr_en, rd_en;

  always_comb begin
    wr_en = wr_inc & ~full_q;
    rd_en = rd_inc & ~empty_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + cnt_t'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + cnt_t'(1);

    // Pointers carry a wrap bit, so their difference is the exact occupancy.
    count_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);

    ovf_d = (wr_inc & full_q)  | (ovf_q & ~clr_err);
    unf_d = (rd_inc & empty_q) | (unf_q & ~clr_err);

    rd_data_d = rd_data_q;
    if (FWFT != 0) begin
      // Present the post-edge head; bypass the write when it lands on the head slot.
      if (wr_en || rd_en) begin
        if (wr_en && (wr_ptr_q[ADDR_SIZE-1:0] == rd_ptr_d[ADDR_SIZE-1:0]))
          rd_data_d = wr_data;
        else
          rd_data_d = mem_q[rd_ptr_d[ADDR_SIZE-1:0]];
      end
    end else if (rd_en) begin
      rd_data_d = mem_q[rd_ptr_q[ADDR_SIZE-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_SIZE-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    rd_data      = rd_data_q;
    wr_full      = full_q;
    rd_empty     = empty_q;
    almost_full  = afull_q;
    almost_empty = aempty_q;
    wr_count     = count_q;
    overflow     = ovf_q;
    underflow    = unf_q;
  end

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Bench for sync_fifo_flagged: registered-read and FWFT instances share one
// stimulus stream and are checked against a queue-based model and vector table.
module tb_sync_fifo_flagged;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_inc = 1'b0, rd_inc = 1'b0, clr_err = 1'b0;

  logic [7:0] rd_data0, rd_data1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] cnt0, cnt1;

  sync_fifo_flagged #(.DATA_SIZE(8), .ADDR_SIZE(4), .AFULL_LVL(14), .AEMPTY_LVL(2), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_inc(wr_inc), .rd_inc(rd_inc), .clr_err(clr_err),
    .rd_data(rd_data0), .wr_full(full0), .rd_empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .wr_count(cnt0), .overflow(ovf0), .underflow(unf0));

  sync_fifo_flagged #(.DATA_SIZE(8), .ADDR_SIZE(4), .AFULL_LVL(14), .AEMPTY_LVL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_inc(wr_inc), .rd_inc(rd_inc), .clr_err(clr_err),
    .rd_data(rd_data1), .wr_full(full1), .rd_empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .wr_count(cnt1), .overflow(ovf1), .underflow(unf1));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: contents as a queue, sticky errors, last word read.
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0, m_unf = 1'b0;
  logic [7:0] m_rd0 = '0;

  typedef struct {
    logic       w, r, c;
    logic [7:0] d;
    int         e_cnt;
    logic       e_empty, e_ovf, e_unf;
    logic [7:0] e_rd;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int sz;
    sz = mq.size();
    chk("count",  32'(cnt0), 32'(sz));
    chk("full",   32'(full0), 32'(sz == DEPTH));
    chk("empty",  32'(empty0), 32'(sz == 0));
    chk("afull",  32'(af0), 32'(sz >= 14));
    chk("aempty", 32'(ae0), 32'(sz <= 2));
    chk("ovf",    32'(ovf0), 32'(m_ovf));
    chk("unf",    32'(unf0), 32'(m_unf));
    chk("rdata",  32'(rd_data0), 32'(m_rd0));
    chk("f_count", 32'(cnt1), 32'(sz));
    chk("f_empty", 32'(empty1), 32'(sz == 0));
    chk("f_full",  32'(full1), 32'(sz == DEPTH));
    chk("f_ovf",   32'(ovf1), 32'(m_ovf));
    chk("f_unf",   32'(unf1), 32'(m_unf));
    if (sz > 0) chk("f_head", 32'(rd_data1), 32'(mq[0]));
  endtask

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    int sz;
    wr_inc = w; rd_inc = r; clr_err = c; wr_data = d;
    @(posedge clk);
    sz = mq.size();
    if (r && sz > 0) m_rd0 = mq.pop_front();
    if (w && sz < DEPTH) mq.push_back(d);
    m_ovf = (w && sz == DEPTH) || (m_ovf && !c);
    m_unf = (r && sz == 0) || (m_unf && !c);
    @(negedge clk);
    wr_inc = 1'b0; rd_inc = 1'b0; clr_err = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_rd0 = '0;
    chk("rst_count", 32'(cnt0), 0);
    chk("rst_full",  32'(full0), 0);
    chk("rst_empty", 32'(empty0), 1);
    chk("rst_af",    32'(af0), 0);
    chk("rst_ae",    32'(ae0), 1);
    chk("rst_ovf",   32'(ovf0), 0);
    chk("rst_unf",   32'(unf0), 0);
    chk("rst_rd0",   32'(rd_data0), 0);
    chk("rst_rd1",   32'(rd_data1), 0);
    chk("rst_f_empty", 32'(empty1), 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] hold;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 8'h33, 1, 1'b0, 1'b0, 1'b0, 8'h22};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h33};

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d);
      chk("vec_count", 32'(cnt0), 32'(tbl[i].e_cnt));
      chk("vec_empty", 32'(empty0), 32'(tbl[i].e_empty));
      chk("vec_ovf",   32'(ovf0), 32'(tbl[i].e_ovf));
      chk("vec_unf",   32'(unf0), 32'(tbl[i].e_unf));
      chk("vec_rdata", 32'(rd_data0), 32'(tbl[i].e_rd));
    end

    // Fill, overflow, clear-vs-set priority, simultaneous access at full, drain.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(i));
      if (i == 2)  chk("ae_after_w3", 32'(ae0), 0);
      if (i == 12) chk("af_before_w14", 32'(af0), 0);
      if (i == 13) chk("af_at_w14", 32'(af0), 1);
    end
    chk("fill_count", 32'(cnt0), 16);
    chk("fill_full", 32'(full0), 1);
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    chk("ovf_set", 32'(ovf0), 1);
    chk("ovf_count", 32'(cnt0), 16);
    step(1'b1, 1'b0, 1'b1, 8'hEF);
    chk("clr_vs_set", 32'(ovf0), 1);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("clr_ovf", 32'(ovf0), 0);
    step(1'b1, 1'b1, 1'b0, 8'hF0);
    chk("full_wr_rd_count", 32'(cnt0), 15);
    chk("full_wr_rd_ovf", 32'(ovf0), 1);
    chk("full_wr_rd_data", 32'(rd_data0), 8'h00);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("drain_data", 32'(rd_data0), 32'(i));
    end
    chk("drain_empty", 32'(empty0), 1);
    hold = rd_data1;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("unf_set", 32'(unf0), 1);
    chk("unf_rdata_hold", 32'(rd_data0), 8'h0F);
    chk("unf_f_rdata_hold", 32'(rd_data1), 32'(hold));

    // Steady occupancy of 5 across pointer wrap.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
      chk("wrap_count", 32'(cnt0), 5);
    end

    // FWFT: word visible the cycle after the write, without a read.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'hA5);
    chk("fwft_empty", 32'(empty1), 0);
    chk("fwft_data", 32'(rd_data1), 8'hA5);

    // Asynchronous reset with count 9 and overflow set.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    step(1'b1, 1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("pre_rst_count", 32'(cnt0), 9);
    chk("pre_rst_ovf", 32'(ovf0), 1);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h5A);
    chk("post_rst_f_data", 32'(rd_data1), 8'h5A);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("post_rst_first", 32'(rd_data0), 8'h5A);

    // Random traffic, write-heavy then read-heavy to reach both ends.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int wb;
      wb = (i < 200) ? 70 : 30;
      step($urandom_range(0, 99) < wb, $urandom_range(0, 99) < (100 - wb),
           $urandom_range(0, 99) < 5, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flagged.md
SYNC_FIFO_FLAGGED -- requirements
Module: sync_fifo_flagged

Interface
REQ-001 The block SHALL take parameter DATA_SIZE, default 8: width of wr_data and rd_data in bits.
REQ-002 The block SHALL take parameter ADDR_SIZE, default 4: storage depth DEPTH = 2**ADDR_SIZE words.
REQ-003 The block SHALL take parameter AFULL_LVL, default DEPTH-2: almost-full threshold, legal range 1..DEPTH.
REQ-004 The block SHALL take parameter AEMPTY_LVL, default 2: almost-empty threshold, legal range 0..DEPTH-1.
REQ-005 The block SHALL take parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-007 The ports SHALL be:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous active-high reset
- wr_data  in  DATA_SIZE  write word
- wr_inc  in  1  write request
- rd_inc  in  1  read request
- clr_err  in  1  clear sticky error flags
- rd_data  out  DATA_SIZE  read word
- wr_full  out  1  FIFO holds DEPTH words
- rd_empty  out  1  FIFO holds 0 words
- almost_full  out  1  count >= AFULL_LVL
- almost_empty  out  1  count <= AEMPTY_LVL
- wr_count  out  ADDR_SIZE+1  current occupancy 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

Function
REQ-008 Write pointer, read pointer and count SHALL be ADDR_SIZE+1 bits; pointers SHALL wrap from DEPTH-1 to 0 with the MSB toggling.
REQ-009 A write SHALL be accepted iff wr_inc=1 and wr_full=0 at the clock edge; wr_data is stored at the write pointer, which then increments.
REQ-010 A read SHALL be accepted iff rd_inc=1 and rd_empty=0 at the clock edge; the read pointer then increments.
REQ-011 Flags are evaluated on pre-edge state: when full, a write SHALL be rejected even if a read is accepted in the same cycle; when empty, a read SHALL be rejected even if a write is accepted in the same cycle.
REQ-012 wr_count SHALL update as follows: +1 on a write only, -1 on a read only, and unchanged when both or neither are accepted.
REQ-013 wr_full, rd_empty, almost_full and almost_empty SHALL be registered, reflect the new count in the cycle after the edge that changes it, and have no combinational path from inputs.
REQ-014 FWFT=0: on an accepted read at edge N, rd_data SHALL present the head word from N+1 and hold it until the next accepted read.
REQ-015 FWFT=1: whenever rd_empty=0, rd_data SHALL equal the head word; a write into an empty FIFO at edge N SHALL give rd_empty=0 and valid rd_data from N+1; an accepted read SHALL advance rd_data to the next word in the following cycle.
REQ-016 overflow SHALL set on any edge with wr_inc=1 and wr_full=1; underflow SHALL set on any edge with rd_inc=1 and rd_empty=1; a rejected request SHALL change no pointer, count or data.
REQ-017 Error flags SHALL clear on an edge with clr_err=1 unless a set condition occurs on the same edge, in which case set wins.
REQ-018 Storage contents SHALL NOT be altered by reset or by rejected writes.

Reset
REQ-019 While rst=1, asynchronously: pointers=0, wr_count=0, rd_empty=1, wr_full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rd_data=0.
REQ-020 Reset asserted mid-operation SHALL discard all stored words; the first write after release SHALL be read back first.
REQ-021 Deassertion of rst SHALL be accepted at any time; the first request is honoured on the first rising clk edge with rst=0.

Verification (DATA_SIZE=8, ADDR_SIZE=4, AFULL_LVL=14, AEMPTY_LVL=2)
REQ-022 Fill: 16 writes of 0x00..0x0F from reset -> wr_count=16, wr_full=1, almost_full=1 from write 14, almost_empty=0 after write 3; a 17th write -> overflow=1, wr_count stays 16.
REQ-023 Drain: 16 reads after fill -> data 0x00..0x0F in order (FWFT=0 one cycle after each read), rd_empty=1; a 17th read -> underflow=1, rd_data unchanged.
REQ-024 Wrap: 40 interleaved write/read pairs at occupancy 5 -> data in order across pointer wrap, wr_count constant at 5.
REQ-025 Boundaries: simultaneous write+read at full -> read accepted, write rejected, overflow=1, wr_count=15; simultaneous write+read at empty -> write accepted, underflow=1, wr_count=1.
REQ-026 FWFT=1: write 0xA5 to empty -> next cycle rd_empty=0, rd_data=0xA5 without rd_inc.
REQ-027 Reset at wr_count=9 with overflow=1 -> all outputs at reset values; clr_err with a coincident overflow condition -> overflow remains 1.
